complex_fu_issue_arbiter: RTL and testbench

//  Arbitrates the shared complex-FU lane between NUM_LANES issue lanes whose packets were steered to the

---
 rtl/complex_fu_issue_arbiter.sv | 123 ++++++++++++
 tb/tb_complex_fu_issue_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/complex_fu_issue_arbiter.sv
// Issue arbiter for the shared complex functional unit. Multiplies are pipelined; divides hold the
// unit for DIV_LAT cycles, and no multiply may land on the writeback port in a divide's done cycle.
module complex_fu_issue_arbiter #(
    parameter int NUM_LANES = 3,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 34,
    parameter int CNT_W     = 6,
    parameter int PERF_W    = 16,
    localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [NUM_LANES-1:0] isDiv_i,
    input  logic                 flush_i,
    output logic [NUM_LANES-1:0] grant_o,
    output logic [LANE_W-1:0]    grantLane_o,
    output logic                 divBusy_o,
    output logic                 divDone_o,
    output logic [PERF_W-1:0]    stallCycles_o
);

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        DIV_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PERF_W-1:0]   stall_q;

    logic [NUM_LANES-1:0] eligible;
    logic                 mul_block;
    logic                 found;
    logic [LANE_W-1:0]    sel;
    logic                 issue_ok;
    logic                 div_granted;

    // A multiply issued now would write back exactly when the divide result does.
    assign mul_block = (state_q == DIV_BUSY) && (cnt_q == CNT_W'(MUL_LAT));

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            eligible[i] = req_i[i] && (isDiv_i[i] ? (state_q == IDLE) : !mul_block);
        end
    end

    always_comb begin : rr_select
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = LANE_W'(idx);
            end
        end
    end

    assign issue_ok    = found && !flush_i && !reset;
    assign div_granted = issue_ok && isDiv_i[sel];

    always_comb begin
        grant_o = '0;
        if (issue_ok) grant_o[sel] = 1'b1;
    end

    assign grantLane_o = issue_ok ? sel : '0;
    assign divBusy_o   = !reset && (state_q != IDLE);
    assign divDone_o   = !reset && (state_q == DIV_DONE);
    assign stallCycles_o = stall_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (div_granted) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CNT_W'(DIV_LAT - 1);
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Squash abandons the divide; a result already on the port in DIV_DONE is unaffected.
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue_ok) rr_ptr_d = (sel == LANE_W'(NUM_LANES - 1)) ? '0 : sel + LANE_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            if ((|req_i) && !issue_ok && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_complex_fu_issue_arbiter.sv
// Scoreboard bench for complex_fu_issue_arbiter: the driver pushes per-cycle expectations from a
// divide-deadline model, a negedge monitor pops and compares; a narrow-counter copy checks saturation.
module tb_complex_fu_issue_arbiter;

    localparam int NUM_LANES = 3;
    localparam int MUL_LAT   = 3;
    localparam int DIV_LAT   = 34;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req_i;
    logic [2:0] isDiv_i;
    logic       flush_i;

    logic [2:0]  grant_o,  grant_s;
    logic [1:0]  lane_o,   lane_s;
    logic        busy_o,   busy_s;
    logic        done_o,   done_s;
    logic [15:0] stall_o;
    logic [3:0]  stall_s;

    always #5 clk = ~clk;

    complex_fu_issue_arbiter #(.NUM_LANES(3), .MUL_LAT(3), .DIV_LAT(34), .CNT_W(6), .PERF_W(16)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .isDiv_i(isDiv_i), .flush_i(flush_i),
        .grant_o(grant_o), .grantLane_o(lane_o), .divBusy_o(busy_o), .divDone_o(done_o),
        .stallCycles_o(stall_o)
    );

    complex_fu_issue_arbiter #(.NUM_LANES(3), .MUL_LAT(3), .DIV_LAT(34), .CNT_W(6), .PERF_W(4)) dut_sat (
        .clk(clk), .reset(reset), .req_i(req_i), .isDiv_i(isDiv_i), .flush_i(flush_i),
        .grant_o(grant_s), .grantLane_o(lane_s), .divBusy_o(busy_s), .divDone_o(done_s),
        .stallCycles_o(stall_s)
    );

    typedef struct {
        logic [2:0]  grant;
        logic [1:0]  lane;
        logic        busy;
        logic        done;
        logic [15:0] stall;
        logic [3:0]  stall_s;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Model state: divide tracked by the absolute cycle its result appears.
    bit m_active;
    int m_done_cyc;
    int m_rr;
    int m_stall;
    int cyc;

    int last_done_cyc;
    int gcount;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] req, input logic [2:0] isdiv, input logic fl, input logic rst);
        exp_t e;
        int   sel;
        bit   fnd;
        bit   blk;
        reset   = rst;
        req_i   = req;
        isDiv_i = isdiv;
        flush_i = fl;
        blk = m_active && (cyc == m_done_cyc - MUL_LAT);
        fnd = 0;
        sel = 0;
        if (!rst && !fl) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                int l;
                l = (m_rr + k) % NUM_LANES;
                if (!fnd && req[l] && (isdiv[l] ? !m_active : !blk)) begin
                    fnd = 1;
                    sel = l;
                end
            end
        end
        e.grant   = fnd ? 3'(1 << sel) : 3'b000;
        e.lane    = fnd ? 2'(sel) : 2'd0;
        e.busy    = !rst && m_active;
        e.done    = !rst && m_active && (cyc == m_done_cyc);
        e.stall   = (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
        e.stall_s = (m_stall > 15) ? 4'hF : 4'(m_stall);
        e.cyc     = cyc;
        sb.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_active = 0;
            m_rr     = 0;
            m_stall  = 0;
        end else begin
            if (req != 3'b000 && !fnd) m_stall++;
            if (fl || (m_active && cyc == m_done_cyc)) m_active = 0;
            if (fnd) begin
                m_rr = (sel + 1) % NUM_LANES;
                if (isdiv[sel]) begin
                    m_active   = 1;
                    m_done_cyc = cyc + DIV_LAT;
                end
            end
        end
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (done_o === 1'b1) last_done_cyc = e.cyc;
            if (grant_o !== 3'b000) gcount++;
            check($sformatf("cycle%0d grant/lane/busy/done/stall/stall4", e.cyc),
                  64'({grant_o, lane_o, busy_o, done_o, stall_o, stall_s}),
                  64'({e.grant, e.lane, e.busy, e.done, e.stall, e.stall_s}));
        end
    end

    initial begin
        int g;
        reset   = 1'b1;
        req_i   = '0;
        isDiv_i = '0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_active = 0; m_rr = 0; m_stall = 0; cyc = 0;
        last_done_cyc = -1;
        gcount = 0;

        // Reset cycle with requests present: no grant, counters already cleared.
        step(3'b111, 3'b000, 1'b0, 1'b1);

        // All-multiply round robin: lanes 0,1,2,0,1,2.
        repeat (6) step(3'b111, 3'b000, 1'b0, 1'b0);
        check("t1_stall_zero", 64'(stall_o), 64'd0);

        // Lane1 divide, then lane0 multiplies every cycle; one cycle blocked before divide done.
        g = cyc;
        step(3'b010, 3'b010, 1'b0, 1'b0);
        gcount = 0;
        repeat (40) step(3'b001, 3'b000, 1'b0, 1'b0);
        check("t2_div_done_cycle", 64'(last_done_cyc), 64'(g + 34));
        check("t3_mul_grants", 64'(gcount), 64'd39);

        // Divide aborted by flush; no result ever appears; new divide granted right after.
        last_done_cyc = -1;
        step(3'b001, 3'b001, 1'b0, 1'b0);
        repeat (9) step(3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b0);
        check("t4_busy_cleared", 64'(busy_o), 64'd0);
        step(3'b010, 3'b010, 1'b0, 1'b0);

        // Lane2 divide stalls behind the busy divider; narrow counter saturates.
        repeat (20) step(3'b100, 3'b100, 1'b0, 1'b0);
        check("t5_stall_count", 64'(stall_o), 64'd21);
        check("t5_stall_saturated", 64'(stall_s), 64'hF);
        check("t4_no_aborted_done", 64'(last_done_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset together with flush mid-divide; pointer returns to lane 0.
        step(3'b001, 3'b000, 1'b1, 1'b1);
        step(3'b000, 3'b000, 1'b0, 1'b0);
        check("t6_stall_reset", 64'(stall_o), 64'd0);
        step(3'b101, 3'b000, 1'b0, 1'b0);

        // Flush in the done cycle still presents the result.
        last_done_cyc = -1;
        g = cyc;
        step(3'b100, 3'b100, 1'b0, 1'b0);
        repeat (33) step(3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b001, 3'b000, 1'b0, 1'b0);
        check("t7_done_under_flush", 64'(last_done_cyc), 64'(g + 34));

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
